// File: rtl/bottle_pkg.sv
// Shared FSM encoding, default window/credit constants and saturating arithmetic
// for the bottle classifier/counter.
package bottle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Class 0 occupies the least significant DIST_W bits.
    localparam logic [35:0] DEF_CLASS_LO     = {12'd39, 12'd15, 12'd10};
    localparam logic [35:0] DEF_CLASS_HI     = {12'd45, 12'd25, 12'd15};
    localparam logic [23:0] DEF_CLASS_CREDIT = {8'd10, 8'd10, 8'd10};

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/bottle_window_classifier.sv
// Combinational window match of a distance against NUM_CLASSES strict (lo, hi)
// windows; the lowest matching class index wins.
module bottle_window_classifier #(
    parameter int DIST_W      = 12,
    parameter int NUM_CLASSES = 3,
    parameter int CLASS_W     = 2
) (
    input  logic [DIST_W-1:0]             distance,
    input  logic [NUM_CLASSES*DIST_W-1:0] class_lo,
    input  logic [NUM_CLASSES*DIST_W-1:0] class_hi,
    output logic                          match,
    output logic [CLASS_W-1:0]            class_idx
);

    always_comb begin
        match     = 1'b0;
        class_idx = '0;
        // Scan downwards so the lowest matching index is the last writer.
        for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
            if (distance > class_lo[k*DIST_W +: DIST_W] &&
                distance < class_hi[k*DIST_W +: DIST_W]) begin
                match     = 1'b1;
                class_idx = CLASS_W'(k);
            end
        end
    end

endmodule

// File: rtl/bottle_classifier_counter.sv
// Debounced bottle classifier with per-class saturating counters and a
// valid/ready event output. Define CREDIT_EN to add the credit accumulator.
module bottle_classifier_counter
    import bottle_pkg::*;
#(
    parameter int                            DIST_W         = 12,
    parameter int                            CNT_W          = 12,
    parameter int                            NUM_CLASSES    = 3,
    parameter logic [NUM_CLASSES*DIST_W-1:0] CLASS_LO       = DEF_CLASS_LO,
    parameter logic [NUM_CLASSES*DIST_W-1:0] CLASS_HI       = DEF_CLASS_HI,
`ifdef CREDIT_EN
    parameter logic [NUM_CLASSES*8-1:0]      CLASS_CREDIT   = DEF_CLASS_CREDIT,
`endif
    parameter int                            STABLE_SAMPLES = 2,
    parameter int                            CLASS_W        = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIST_W-1:0]            distance_out,
    input  logic                         done,
    input  logic                         clear,
`ifdef CREDIT_EN
    input  logic                         credit_redeem,
    output logic [15:0]                  credit_total,
`endif
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [CLASS_W-1:0]           evt_class,
    output logic [NUM_CLASSES*CNT_W-1:0] count_bus,
    output logic [CNT_W-1:0]             error_cnt,
    output logic                         error,
    output logic                         overrun
);

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    state_t               state, state_next;
    logic [3:0]           streak, streak_next;
    logic [CLASS_W-1:0]   cur, cur_next;
    logic                 done_q;
    logic                 sample;
    logic                 match;
    logic [CLASS_W-1:0]   cls;
    logic                 commit, unmatched, dropped;

    bottle_window_classifier #(
        .DIST_W      (DIST_W),
        .NUM_CLASSES (NUM_CLASSES),
        .CLASS_W     (CLASS_W)
    ) u_classifier (
        .distance  (distance_out),
        .class_lo  (CLASS_LO),
        .class_hi  (CLASS_HI),
        .match     (match),
        .class_idx (cls)
    );

    assign sample    = done & ~done_q;
    assign evt_valid = (state == ST_REPORT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            streak <= '0;
            cur    <= '0;
            done_q <= 1'b0;
        end else if (clear) begin
            state  <= ST_IDLE;
            streak <= '0;
            cur    <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state  <= state_next;
            streak <= streak_next;
            cur    <= cur_next;
            done_q <= done;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, otherwise missing branches infer latches.
        state_next  = state;
        streak_next = streak;
        cur_next    = cur;
        commit      = 1'b0;
        unmatched   = 1'b0;
        dropped     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample && match) begin
                    if (STABLE_SAMPLES == 1) begin
                        state_next = ST_REPORT;
                        commit     = 1'b1;
                    end else begin
                        state_next  = ST_TRACK;
                        cur_next    = cls;
                        streak_next = 4'd1;
                    end
                end else if (sample) begin
                    unmatched = 1'b1;
                end
            end
            ST_TRACK: begin
                if (sample && match) begin
                    if (cls != cur) begin
                        cur_next    = cls;
                        streak_next = 4'd1;
                    end else if (streak + 4'd1 == 4'(STABLE_SAMPLES)) begin
                        state_next  = ST_REPORT;
                        streak_next = '0;
                        commit      = 1'b1;
                    end else begin
                        streak_next = streak + 4'd1;
                    end
                end else if (sample) begin
                    state_next  = ST_IDLE;
                    streak_next = '0;
                    unmatched   = 1'b1;
                end
            end
            ST_REPORT: begin
                dropped = sample;
                if (evt_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: counters are individual flops, not a RAM, so they take the async reset.
            count_bus <= '0;
            error_cnt <= '0;
            error     <= 1'b0;
            overrun   <= 1'b0;
            evt_class <= '0;
        end else if (clear) begin
            count_bus <= '0;
            error_cnt <= '0;
            error     <= 1'b0;
            overrun   <= 1'b0;
            evt_class <= '0;
        end else begin
            if (commit) begin
                evt_class <= cls;
                error     <= 1'b0;
            end
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (commit && cls == CLASS_W'(i))
                    count_bus[i*CNT_W +: CNT_W] <=
                        CNT_W'(sat_add(32'(count_bus[i*CNT_W +: CNT_W]), 32'd1, CNT_MAX));
            end
            if (unmatched) begin
                error_cnt <= CNT_W'(sat_add(32'(error_cnt), 32'd1, CNT_MAX));
                error     <= 1'b1;
            end
            if (dropped) overrun <= 1'b1;
        end
    end

`ifdef CREDIT_EN
    logic [31:0] credit_add;

    assign credit_add = 32'(CLASS_CREDIT[{cls, 3'b000} +: 8]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_total <= '0;
        end else if (clear) begin
            credit_total <= '0;
        end else if (commit) begin
            // Redeem and commit together leave only the new bottle's credit.
            credit_total <= credit_redeem ? credit_add[15:0]
                          : 16'(sat_add(32'(credit_total), credit_add, 32'h0000_FFFF));
        end else if (credit_redeem) begin
            credit_total <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_bottle_classifier_counter.sv
// Directed self-checking bench for bottle_classifier_counter; build with
// +define+CREDIT_EN to also exercise the credit accumulator.
module tb_bottle_classifier_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] distance_out;
    logic        done;
    logic        clear;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_class;
    logic [35:0] count_bus;
    logic [11:0] error_cnt;
    logic        error;
    logic        overrun;
`ifdef CREDIT_EN
    logic        credit_redeem;
    logic [15:0] credit_total;
`endif

    int          errors = 0;
    int          checks = 0;
    int          ev_cnt = 0;
    logic        last_valid;
    logic [1:0]  last_cls;

    always #5 clk = ~clk;

    bottle_classifier_counter dut (
        .clk          (clk),
        .rst          (rst),
        .distance_out (distance_out),
        .done         (done),
        .clear        (clear),
`ifdef CREDIT_EN
        .credit_redeem(credit_redeem),
        .credit_total (credit_total),
`endif
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_class    (evt_class),
        .count_bus    (count_bus),
        .error_cnt    (error_cnt),
        .error        (error),
        .overrun      (overrun)
    );

    // One rising edge of done; the cycle after the sampling edge is captured
    // so one-cycle event pulses are observed.
    task automatic send_sample(input logic [11:0] d);
        @(negedge clk);
        distance_out = d;
        done         = 1'b1;
        @(negedge clk);
        last_valid = evt_valid;
        last_cls   = evt_class;
        if (evt_valid && evt_ready) ev_cnt++;
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic expect_all_zero(input string tag);
        checks++;
        if ({count_bus, error_cnt, error, overrun, evt_valid, evt_class} !== '0) begin
            errors++;
            $display("FAIL %s: cnt=%h err_cnt=%h err=%b ovr=%b valid=%b cls=%0d, required all zero",
                     tag, count_bus, error_cnt, error, overrun, evt_valid, evt_class);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; done = 1'b0; clear = 1'b0; evt_ready = 1'b1; distance_out = '0;
`ifdef CREDIT_EN
        credit_redeem = 1'b0;
`endif
        #12;
        expect_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stable_pair();
        int ev0 = ev_cnt;
        send_sample(12'd42);
        checks++;
        if (last_valid !== 1'b0) begin errors++; $display("FAIL pair_first_no_evt: got %b want 0", last_valid); end
        send_sample(12'd42);
        checks++;
        if (ev_cnt - ev0 !== 1 || last_cls !== 2'd2) begin
            errors++; $display("FAIL pair_event: events=%0d class=%0d want 1 class 2", ev_cnt - ev0, last_cls);
        end
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL pair_pulse_len: got %b want 0", evt_valid); end
        checks++;
        if (count_bus !== {12'd1, 12'd0, 12'd0}) begin
            errors++; $display("FAIL pair_count: got %h want %h", count_bus, {12'd1, 12'd0, 12'd0});
        end
    endtask

    task automatic test_class_switch();
        int ev0 = ev_cnt;
        send_sample(12'd20);
        send_sample(12'd12);
        checks++;
        if (ev_cnt !== ev0) begin errors++; $display("FAIL switch_no_evt: events=%0d want 0", ev_cnt - ev0); end
        send_sample(12'd12);
        send_sample(12'd12);
        checks++;
        if (ev_cnt - ev0 !== 1 || count_bus !== {12'd1, 12'd0, 12'd1}) begin
            errors++; $display("FAIL switch_event: events=%0d cnt=%h want 1 %h", ev_cnt - ev0, count_bus, {12'd1, 12'd0, 12'd1});
        end
    endtask

    task automatic test_unmatched();
        int ev0 = ev_cnt;
        send_sample(12'd15);
        send_sample(12'd30);
        checks++;
        if (error_cnt !== 12'd2 || error !== 1'b1 || ev_cnt !== ev0) begin
            errors++; $display("FAIL unmatched: err_cnt=%0d err=%b events=%0d want 2 1 0", error_cnt, error, ev_cnt - ev0);
        end
        send_sample(12'd20);
        send_sample(12'd20);
        checks++;
        if (count_bus !== {12'd1, 12'd1, 12'd1} || error !== 1'b0 || error_cnt !== 12'd2) begin
            errors++; $display("FAIL unmatched_recover: cnt=%h err=%b err_cnt=%0d want %h 0 2",
                               count_bus, error, error_cnt, {12'd1, 12'd1, 12'd1});
        end
    endtask

    task automatic test_overrun();
        evt_ready = 1'b0;
        send_sample(12'd42);
        send_sample(12'd42);
        checks++;
        if (last_valid !== 1'b1 || count_bus !== {12'd2, 12'd1, 12'd1}) begin
            errors++; $display("FAIL overrun_commit: valid=%b cnt=%h want 1 %h", last_valid, count_bus, {12'd2, 12'd1, 12'd1});
        end
        send_sample(12'd12);
        send_sample(12'd20);
        send_sample(12'd15);
        checks++;
        if (evt_valid !== 1'b1 || evt_class !== 2'd2 || overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_hold: valid=%b cls=%0d ovr=%b want 1 2 1", evt_valid, evt_class, overrun);
        end
        checks++;
        if (count_bus !== {12'd2, 12'd1, 12'd1} || error_cnt !== 12'd2) begin
            errors++; $display("FAIL overrun_counts: cnt=%h err_cnt=%0d want %h 2", count_bus, error_cnt, {12'd2, 12'd1, 12'd1});
        end
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_release: valid=%b ovr=%b want 0 1", evt_valid, overrun);
        end
    endtask

    task automatic test_clear_vs_sample();
        clear_pulse();
        @(negedge clk);
        expect_all_zero("clear_all");
        distance_out = 12'd12;
        done         = 1'b1;
        clear        = 1'b1;
        @(negedge clk);
        done  = 1'b0;
        clear = 1'b0;
        send_sample(12'd12);
        checks++;
        if (last_valid !== 1'b0 || count_bus !== '0) begin
            errors++; $display("FAIL clear_wins: valid=%b cnt=%h want 0 0", last_valid, count_bus);
        end
        send_sample(12'd12);
        checks++;
        if (last_valid !== 1'b1 || count_bus !== {12'd0, 12'd0, 12'd1}) begin
            errors++; $display("FAIL clear_then_pair: valid=%b cnt=%h want 1 %h", last_valid, count_bus, {12'd0, 12'd0, 12'd1});
        end
    endtask

    task automatic test_done_held();
        @(negedge clk);
        distance_out = 12'd42;
        done         = 1'b1;
        repeat (5) @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0 || count_bus !== {12'd0, 12'd0, 12'd1}) begin
            errors++; $display("FAIL done_held_single: valid=%b cnt=%h want 0 %h", evt_valid, count_bus, {12'd0, 12'd0, 12'd1});
        end
        send_sample(12'd42);
        checks++;
        if (last_valid !== 1'b1 || last_cls !== 2'd2 || count_bus !== {12'd1, 12'd0, 12'd1}) begin
            errors++; $display("FAIL done_held_follow: valid=%b cls=%0d cnt=%h want 1 2 %h",
                               last_valid, last_cls, count_bus, {12'd1, 12'd0, 12'd1});
        end
    endtask

    task automatic test_saturation();
        clear_pulse();
        for (int i = 0; i < 4096; i++) begin
            send_sample(12'd12);
            send_sample(12'd12);
        end
        checks++;
        if (count_bus !== {12'd0, 12'd0, 12'hFFF} || error_cnt !== 12'd0) begin
            errors++; $display("FAIL saturate: cnt=%h err_cnt=%h want %h 0", count_bus, error_cnt, {12'd0, 12'd0, 12'hFFF});
        end
        clear_pulse();
        @(negedge clk);
        expect_all_zero("clear_after_sat");
    endtask

    task automatic test_reset_mid_report();
        evt_ready = 1'b0;
        send_sample(12'd42);
        send_sample(12'd42);
        checks++;
        if (evt_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", evt_valid); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        expect_all_zero("async_reset_report");
        @(negedge clk);
        rst       = 1'b1;
        evt_ready = 1'b1;
    endtask

`ifdef CREDIT_EN
    task automatic test_credit();
        for (int i = 0; i < 3; i++) begin
            send_sample(12'd42);
            send_sample(12'd42);
        end
        checks++;
        if (credit_total !== 16'd30) begin errors++; $display("FAIL credit_sum: got %0d want 30", credit_total); end
        send_sample(12'd42);
        @(negedge clk);
        distance_out  = 12'd42;
        done          = 1'b1;
        credit_redeem = 1'b1;
        @(negedge clk);
        done          = 1'b0;
        credit_redeem = 1'b0;
        @(negedge clk);
        checks++;
        if (credit_total !== 16'd10 || count_bus !== {12'd4, 12'd0, 12'd0}) begin
            errors++; $display("FAIL credit_redeem_commit: credit=%0d cnt=%h want 10 %h", credit_total, count_bus, {12'd4, 12'd0, 12'd0});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stable_pair();
        test_class_switch();
        test_unmatched();
        test_overrun();
        test_clear_vs_sample();
        test_done_held();
        test_saturation();
        test_reset_mid_report();
`ifdef CREDIT_EN
        test_credit();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
